// File: rtl/counter_master.sv
// Sequencer for the external counter block: programs the enable and time bytes,
// starts a measurement, waits for the end flag, then reads back all results.
module counter_master #(
  parameter int unsigned             DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]   BASE_ADDR  = 8'h26,
  parameter logic [31:0]             TIMEOUT    = 32'd400000000
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  cmd_go,
  input  logic [3:0]            cmd_enable,
  input  logic [7:0]            cmd_time,
  output logic [DATA_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  we,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0][31:0]      res_data,
  output logic [31:0]           res_time
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CTRL, S_WR_TIME, S_START, S_WAIT_HI,
    S_WAIT_LO, S_READ, S_DONE, S_ERR
  } state_t;

  localparam logic [4:0] LAST_ISSUE = 5'd19;
  localparam logic [4:0] LAST_READ  = 5'd20;

  state_t      state;
  logic        phase;
  logic [7:0]  time_q;
  logic [4:0]  rd_cnt;
  logic [31:0] wait_cnt;
  logic [31:0] wait_nxt;
  logic        timeout_hit;
  logic [4:0]  byte_idx;
  logic [4:0]  lane_lsb;

  // Channel 0 lands in the MSB of the control byte; the low nibble is reserved.
  function automatic logic [7:0] ctrl_byte(input logic [3:0] en);
    return {en[0], en[1], en[2], en[3], 4'b0000};
  endfunction

  always_comb begin
    wait_nxt    = (wait_cnt == '1) ? wait_cnt : wait_cnt + 32'd1;
    timeout_hit = (wait_nxt >= TIMEOUT);
  end

  // rd_data lags addr by one cycle, so read cycle k stores the byte issued in k-1.
  assign byte_idx = rd_cnt - 5'd1;
  assign lane_lsb = {byte_idx[1:0], 3'b000};

  // NOTE: all state here is updated with <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= S_IDLE;
      phase    <= 1'b0;
      time_q   <= '0;
      rd_cnt   <= '0;
      wait_cnt <= '0;
      addr     <= '0;
      wr_data  <= '0;
      we       <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      // NOTE: result registers are plain flops (not a RAM), so they are reset.
      res_data <= '0;
      res_time <= '0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_go) begin
            time_q  <= cmd_time;
            busy    <= 1'b1;
            addr    <= BASE_ADDR;
            wr_data <= DATA_WIDTH'(ctrl_byte(cmd_enable));
            we      <= 1'b1;
            phase   <= 1'b0;
            state   <= S_WR_CTRL;
          end
        end
        S_WR_CTRL: begin
          if (!phase) begin
            we    <= 1'b0;
            phase <= 1'b1;
          end else begin
            addr    <= BASE_ADDR + DATA_WIDTH'(1);
            wr_data <= DATA_WIDTH'(time_q);
            we      <= 1'b1;
            phase   <= 1'b0;
            state   <= S_WR_TIME;
          end
        end
        S_WR_TIME: begin
          if (!phase) begin
            we    <= 1'b0;
            phase <= 1'b1;
          end else begin
            start <= 1'b1;
            phase <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (stop) begin
            wait_cnt <= '0;
            state    <= S_WAIT_LO;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        S_WAIT_LO: begin
          if (!stop) begin
            addr   <= BASE_ADDR + DATA_WIDTH'(2);
            rd_cnt <= '0;
            state  <= S_READ;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        S_READ: begin
          if (rd_cnt != 5'd0) begin
            case (byte_idx[4:2])
              3'd0:    res_data[0][lane_lsb +: 8] <= rd_data[7:0];
              3'd1:    res_time[lane_lsb +: 8]    <= rd_data[7:0];
              3'd2:    res_data[1][lane_lsb +: 8] <= rd_data[7:0];
              3'd3:    res_data[2][lane_lsb +: 8] <= rd_data[7:0];
              3'd4:    res_data[3][lane_lsb +: 8] <= rd_data[7:0];
              default: ;
            endcase
          end
          if (rd_cnt < LAST_ISSUE) addr <= addr + DATA_WIDTH'(1);
          if (rd_cnt == LAST_READ) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            rd_cnt <= rd_cnt + 5'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR: begin
          we    <= 1'b0;
          start <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_master.sv
// Directed bench for counter_master: a behavioural counter block (CLK_FREQ=1000)
// serves the main instance, a second instance with TIMEOUT=100 sees a dead stop line.
module tb_counter_master;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int          LIMIT    = 10000;

  logic             clk = 1'b0;
  logic             res_n;
  logic             cmd_go;
  logic [3:0]       cmd_enable;
  logic [7:0]       cmd_time;
  logic [7:0]       addr, wr_data, rd_data;
  logic             we, start, stop, busy, done, err;
  logic [3:0][31:0] res_data;
  logic [31:0]      res_time;

  logic             go_t;
  logic [7:0]       addr_t, wr_data_t;
  logic             we_t, start_t, busy_t, done_t, err_t;
  logic [3:0][31:0] res_data_t;
  logic [31:0]      res_time_t;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  counter_master dut (
    .clk(clk), .res_n(res_n), .cmd_go(cmd_go), .cmd_enable(cmd_enable),
    .cmd_time(cmd_time), .addr(addr), .wr_data(wr_data), .we(we),
    .rd_data(rd_data), .start(start), .stop(stop), .busy(busy),
    .done(done), .err(err), .res_data(res_data), .res_time(res_time)
  );

  counter_master #(.TIMEOUT(32'd100)) dut_to (
    .clk(clk), .res_n(res_n), .cmd_go(go_t), .cmd_enable(4'b1111),
    .cmd_time(8'd3), .addr(addr_t), .wr_data(wr_data_t), .we(we_t),
    .rd_data(8'hA5), .start(start_t), .stop(1'b0), .busy(busy_t),
    .done(done_t), .err(err_t), .res_data(res_data_t), .res_time(res_time_t)
  );

  // Behavioural counter block: control/time registers, timed measurement, stop flag.
  logic [7:0]  m_ctrl, m_time;
  logic        measuring;
  int unsigned remaining, elapsed, stop_hold;
  logic [31:0] m_cnt [4];
  logic [31:0] m_tword;
  int unsigned npulse [4];
  logic [3:0]  sig;

  always_comb begin
    sig = '0;
    for (int i = 0; i < 4; i++)
      if (measuring && remaining != 0 && (elapsed % 2) == 0 && (elapsed / 2) < npulse[i])
        sig[i] = 1'b1;
  end

  function automatic logic [7:0] model_byte(input logic [7:0] a);
    logic [7:0]  off;
    logic [31:0] w;
    off = a - 8'h28;
    if (a < 8'h28 || a > 8'h3b) return 8'h00;
    case (off / 4)
      0:       w = m_cnt[0];
      1:       w = m_tword;
      2:       w = m_cnt[1];
      3:       w = m_cnt[2];
      default: w = m_cnt[3];
    endcase
    return w[8*(off % 4) +: 8];
  endfunction

  assign stop = (stop_hold != 0);

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      m_ctrl <= '0; m_time <= '0; measuring <= 1'b0; remaining <= 0;
      elapsed <= 0; stop_hold <= 0; m_tword <= '0; rd_data <= '0;
      for (int i = 0; i < 4; i++) m_cnt[i] <= '0;
    end else begin
      if (we && addr == 8'h26) m_ctrl <= wr_data;
      if (we && addr == 8'h27) m_time <= wr_data;
      if (stop_hold != 0) stop_hold <= stop_hold - 1;
      if (start) begin
        measuring <= 1'b1;
        remaining <= m_time * CLK_FREQ;
        elapsed   <= 0;
        for (int i = 0; i < 4; i++) m_cnt[i] <= '0;
      end else if (measuring) begin
        if (remaining == 0) begin
          measuring <= 1'b0;
          stop_hold <= 4;
          m_tword   <= elapsed;
        end else begin
          remaining <= remaining - 1;
          elapsed   <= elapsed + 1;
          for (int i = 0; i < 4; i++)
            if (sig[i] && m_ctrl[7-i]) m_cnt[i] <= m_cnt[i] + 1;
        end
      end
      rd_data <= model_byte(addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_results(input logic [31:0] e0, e1, e2, e3, et);
    check("res_data0", res_data[0], e0);
    check("res_data1", res_data[1], e1);
    check("res_data2", res_data[2], e2);
    check("res_data3", res_data[3], e3);
    check("res_time", res_time, et);
  endtask

  // One full command on the main instance with bus-timing bookkeeping.
  task automatic run_seq(input logic [3:0] en, input logic [7:0] tm, input logic [7:0] exp_ctrl,
                         input bit hold_go, input int exp_first_we);
    int first_we, start_cyc, start_hi, read_start, done_cyc, nw, bad_rd, hold_at, nerr, k;
    logic [7:0] wa [2];
    logic [7:0] wd [2];
    logic [7:0] ha, hd;
    logic       busy_d;
    first_we = -1; start_cyc = -1; start_hi = 0; read_start = -1; done_cyc = -1;
    nw = 0; bad_rd = 0; hold_at = -1; nerr = 0; busy_d = 1'bx; ha = '0; hd = '0;
    cmd_enable = en; cmd_time = tm; cmd_go = 1'b1;
    for (int i = 1; i <= LIMIT && done_cyc < 0; i++) begin
      @(negedge clk);
      if (!hold_go && busy) cmd_go = 1'b0;
      if (hold_at == i) check("wr_hold", {we, addr, wr_data}, {1'b0, ha, hd});
      if (we) begin
        if (first_we < 0) first_we = i;
        if (nw < 2) begin wa[nw] = addr; wd[nw] = wr_data; end
        nw++; ha = addr; hd = wr_data; hold_at = i + 1;
      end
      if (start) begin
        if (start_cyc < 0) start_cyc = i;
        start_hi++;
      end
      if (err) nerr++;
      if (start_cyc >= 0 && read_start < 0 && addr == 8'h28) read_start = i;
      if (done) begin
        done_cyc = i;
        busy_d   = busy;
      end else if (read_start >= 0) begin
        k = i - read_start;
        if (addr != 8'h28 + (k < 19 ? k : 19) || we) bad_rd++;
      end
    end
    if (done_cyc < 0) check("seq_timeout", 0, 1);
    check("first_we", first_we, exp_first_we);
    check("n_writes", nw, 2);
    check("wr0_addr", wa[0], 8'h26);
    check("wr0_data", wd[0], exp_ctrl);
    check("wr1_addr", wa[1], 8'h27);
    check("wr1_data", wd[1], tm);
    check("start_lag", start_cyc - first_we, 4);
    check("start_width", start_hi, 1);
    check("read_cycles", done_cyc - read_start, 21);
    check("read_addr_bad", bad_rd, 0);
    check("busy_at_done", busy_d, 0);
    check("err_in_seq", nerr, 0);
  endtask

  initial begin
    int s, e, nd, ne;
    logic busy_e;
    res_n = 1'b0; cmd_go = 1'b0; cmd_enable = '0; cmd_time = '0; go_t = 1'b0;
    for (int i = 0; i < 4; i++) npulse[i] = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_outs", {we, start, done, err, addr, wr_data}, 0);
    check("rst_res", res_data[0] | res_data[3] | res_time, 0);
    check("rst_to_busy", {busy_t, err_t}, 0);
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);

    // Single channel, disabled channels also see pulses and must stay zero.
    npulse[0] = 5; npulse[1] = 4; npulse[2] = 4; npulse[3] = 4;
    run_seq(4'b0001, 8'd2, 8'h80, 1'b0, 1);
    check_results(32'd5, 32'd0, 32'd0, 32'd0, 32'd2000);

    // All channels enabled.
    repeat (10) @(negedge clk);
    npulse[0] = 2; npulse[1] = 3; npulse[2] = 7; npulse[3] = 9;
    run_seq(4'b1111, 8'd1, 8'hF0, 1'b0, 1);
    check_results(32'd2, 32'd3, 32'd7, 32'd9, 32'd1000);

    // Timeout instance: stop never rises.
    s = -1; e = -1; busy_e = 1'bx;
    go_t = 1'b1;
    for (int i = 1; i <= 1000 && e < 0; i++) begin
      @(negedge clk);
      if (busy_t) go_t = 1'b0;
      if (start_t && s < 0) s = i;
      if (err_t) begin e = i; busy_e = busy_t; end
    end
    check("to_err_lag", e - s, 101);
    check("to_busy_at_err", busy_e, 0);
    @(negedge clk);
    check("to_err_width", {err_t, done_t, busy_t}, 0);
    check("to_results", res_data_t[0] | res_data_t[1] | res_data_t[2] | res_data_t[3] | res_time_t, 0);

    // Reset during the wait for stop, then a fresh command.
    cmd_enable = 4'b1111; cmd_time = 8'd1; cmd_go = 1'b1; s = -1;
    for (int i = 1; i <= 100 && s < 0; i++) begin
      @(negedge clk);
      if (busy) cmd_go = 1'b0;
      if (start) s = i;
    end
    check("abort_start_seen", s > 0, 1);
    repeat (20) @(negedge clk);
    check("abort_in_wait", {busy, done, err}, 3'b100);
    res_n = 1'b0;
    #1;
    check("abort_rst_outs", {busy, we, start, done, err, addr}, 0);
    check("abort_rst_res1", res_data[1], 0);
    check("abort_rst_time", res_time, 0);
    @(negedge clk);
    res_n = 1'b1;
    nd = 0; ne = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
      if (err) ne++;
    end
    check("abort_no_pulse", {nd[15:0], ne[15:0]}, 0);
    npulse[0] = 6; npulse[1] = 1; npulse[2] = 8; npulse[3] = 2;
    run_seq(4'b0101, 8'd1, 8'hA0, 1'b0, 1);
    check_results(32'd6, 32'd0, 32'd8, 32'd0, 32'd1000);

    // cmd_go held high with a zero count time: back-to-back sequences.
    repeat (5) @(negedge clk);
    run_seq(4'b0011, 8'd0, 8'hC0, 1'b1, 1);
    check_results(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    run_seq(4'b0011, 8'd0, 8'hC0, 1'b0, 2);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("hold_go_extra_done", nd, 0);
    check("hold_go_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_master.md
COUNTER_MASTER -- requirements
Module: counter_master

Interface
REQ-001 Parameters, one per line:
- DATA_WIDTH, 8, register bus byte width.
- BASE_ADDR, 8'h26, address of the counter control byte.
- TIMEOUT, 32'd400000000, maximum cycles spent in any wait state.
REQ-002 Ports, one per line: name  direction  width  meaning:
- clk  in  1  single clock.
- res_n  in  1  reset, asynchronous, active-low.
- cmd_go  in  1  start one measurement; sampled only in S_IDLE.
- cmd_enable  in  4  channel enable; bit i enables signal channel i.
- cmd_time  in  8  count time in seconds.
- addr  out  DATA_WIDTH  register address to the counter.
- wr_data  out  DATA_WIDTH  write data to the counter's data_in.
- we  out  1  write strobe to the counter.
- rd_data  in  DATA_WIDTH  counter's registered data_out.
- start  out  1  measurement start pulse to the counter.
- stop  in  1  counter end-of-measurement flag.
- busy  out  1  high from cmd_go acceptance until the DONE or ERR cycle.
- done  out  1  one-cycle pulse; results valid.
- err  out  1  one-cycle pulse; timeout abort.
- res_data  out  4x32  channel counts, index = channel.
- res_time  out  32  counter time word.

Function
REQ-003 States: S_IDLE, S_WR_CTRL, S_WR_TIME, S_START, S_WAIT_HI, S_WAIT_LO, S_READ, S_DONE, S_ERR; every output shall be registered.
REQ-004 S_IDLE with cmd_go=1 shall latch cmd_enable and cmd_time, set busy, and enter S_WR_CTRL; cmd_go shall be ignored in every other state.
REQ-005 Every bus write shall take exactly 2 cycles:
- Cycle A: we=1, with addr and wr_data valid.
- Cycle B: we=0, with addr and wr_data held.
REQ-006 S_WR_CTRL shall write addr=BASE_ADDR with wr_data={en[0],en[1],en[2],en[3],4'b0000}; bit 0 shall always be 0.
REQ-007 S_WR_TIME shall write addr=BASE_ADDR+1 with wr_data=cmd_time.
REQ-008 S_START shall drive start=1 for exactly one cycle, occurring 4 cycles after the first we; the FSM shall then enter S_WAIT_HI.
REQ-009 S_WAIT_HI shall wait for stop=1, then enter S_WAIT_LO.
REQ-010 S_WAIT_LO shall wait for stop=0, then enter S_READ.
REQ-011 The wait counter shall clear on entry to each wait state; reaching TIMEOUT in a wait state shall enter S_ERR.
REQ-012 S_READ shall run a pipelined read over 21 cycles:
- addr shall step by 1 per cycle from BASE_ADDR+2 through BASE_ADDR+21.
- The byte for the address issued in cycle k shall be captured at the end of cycle k+1.
- we shall stay 0 throughout.
REQ-013 Byte-to-result mapping, little-endian within each word:
- BASE+2..5 -> res_data[0].
- BASE+6..9 -> res_time.
- BASE+10..13 -> res_data[1].
- BASE+14..17 -> res_data[2].
- BASE+18..21 -> res_data[3].
REQ-014 Result registers shall update only in S_READ; they shall hold their values otherwise, including through S_ERR.
REQ-015 S_DONE shall pulse done=1 for one cycle, clear busy, and return to S_IDLE.
REQ-016 S_ERR shall pulse err=1 for one cycle, clear busy, drive start=0 and we=0, and return to S_IDLE.
REQ-017 cmd_time=0 shall be legal; the counter ends immediately and the sequence shall be unchanged.
REQ-018 If stop is already 1 on entry to S_WAIT_HI, the FSM shall advance on the next cycle.
REQ-019 Address arithmetic shall be modulo 2^DATA_WIDTH.
REQ-020 The wait counter shall be 32 bits and shall saturate, never wrap.

Reset
REQ-021 res_n=0 shall asynchronously force:
- state=S_IDLE.
- addr, wr_data, we, start, busy, done, err = 0.
- res_data[0..3], res_time, wait counter = 0.
REQ-022 Asserting res_n mid-sequence shall abort with no done or err pulse; the first command after release shall start a full sequence.

Verification
REQ-023 Bench shall pair the DUT with the counter block (CLK_FREQ=1000) and cover:
- Go with cmd_enable=4'b0001, cmd_time=2, and 5 pulses on channel 0 -> write 0x26<=0x80, write 0x27<=0x02, start pulse, then done, with res_data[0]=5 and res_data[1..3]=0.
- Go with cmd_enable=4'b1111, cmd_time=1, and channels 1..3 receiving 3, 7, 9 pulses -> res_data[1..3]=3, 7, 9 after done.
- Responder stub that never raises stop, with TIMEOUT=100 -> err pulse exactly 100 cycles after entering S_WAIT_HI, busy=0, results unchanged.
- Bus timing check -> each we high for 1 cycle, addr/wr_data stable for 2 cycles, start 4 cycles after the first we, 21 read cycles covering addresses 0x28..0x3b.
- res_n pulsed low during S_WAIT_HI, then a new go -> no done or err pulse from the aborted run, and the new sequence completes with correct results.
- cmd_go held high for the full run, with cmd_time=0 -> exactly one done per sequence, and a second run starting in the cycle after done.
